// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hamming_pkg
// Description : Shared definitions for the Hamming(15,11)+overall-parity
//               SECDED codec: codeword/message widths, decoder FSM state
//               encoding, result status encoding, and the data-extract
//               function shared with the encoder.
//               Codeword layout (bit i = Hamming position i):
//                 {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
//               Bit 0 carries the overall (even) parity.
// Revision    : 1.0  initial release
// ============================================================================
package hamming_pkg;

  localparam int CODE_W = 16;
  localparam int DATA_W = 11;

  // Decoder FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Result classification presented on out_status.
  typedef enum logic [1:0] {
    STAT_CLEAN  = 2'b00,  // no error seen
    STAT_SINGLE = 2'b01,  // single error at position 1..15, corrected
    STAT_DOUBLE = 2'b10,  // two errors, not correctable
    STAT_P0     = 2'b11   // only the overall parity bit was wrong
  } status_e;

  // Pull the message bits out of a codeword. Message bits sit at every
  // position that is neither 0 nor a power of two, in ascending order,
  // so d1 lands at result bit 0 and d11 at result bit 10.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    logic [3:0]        k;
    d = '0;
    k = 4'd0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = code[i[3:0]];
        k    = k + 4'd1;
      end
    end
    return d;
  endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_decoder
// Description : Bit-serial SECDED decoder for a 16-bit Hamming codeword.
//               A word is accepted in IDLE, scanned one bit per cycle for
//               16 cycles (accumulating syndrome and overall parity),
//               classified/corrected in FIX, and held in DONE until the
//               consumer takes it. Saturating 8-bit counters track single
//               (status 01/11) and double (status 10) error results.
// Ports       : clk        in   rising-edge clock
//               reset      in   asynchronous active-low reset
//               in_valid   in   codeword offered
//               in_ready   out  decoder can accept a codeword (IDLE only)
//               in_code    in   [15:0] codeword, bit i = Hamming position i
//               out_valid  out  result held (DONE only)
//               out_ready  in   consumer takes result
//               out_data   out  [10:0] corrected message d11..d1
//               out_status out  [1:0] 00 clean, 01 single corrected,
//                                     10 double, 11 p0-only error
//               err1_cnt   out  [7:0] saturating single-error result count
//               err2_cnt   out  [7:0] saturating double-error result count
// Revision    : 1.0  initial release
// ============================================================================
module hamming_secded_decoder
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_data,
  output logic [1:0]        out_status,
  output logic [7:0]        err1_cnt,
  output logic [7:0]        err2_cnt
);

  localparam logic [7:0] c_CNT_MAX = 8'hFF;
  localparam logic [3:0] c_LAST    = 4'd15;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              r_state;
  logic [CODE_W-1:0]   r_code;
  logic [3:0]          r_syn;
  logic                r_par;
  logic [3:0]          r_cnt;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_out_data;
  logic [1:0]          r_out_status;
  logic [7:0]          r_err1;
  logic [7:0]          r_err2;

  // --------------------------------------------------------------------------
  // Classification of the scanned word (only consumed in FIX)
  // --------------------------------------------------------------------------
  logic                w_syn_nz;
  logic [CODE_W-1:0]   w_flip_mask;
  logic [CODE_W-1:0]   w_fixed;
  status_e             w_status;
  logic [DATA_W-1:0]   w_data;
  logic                w_inc1;
  logic                w_inc2;

  always_comb begin
    w_syn_nz    = |r_syn;
    w_flip_mask = {{(CODE_W-1){1'b0}}, 1'b1} << r_syn;
    w_fixed     = r_code ^ w_flip_mask;
    w_status    = STAT_CLEAN;
    w_data      = extract_data(r_code);
    case ({w_syn_nz, r_par})
      2'b00: begin
        w_status = STAT_CLEAN;
      end
      2'b01: begin
        // Syndrome points at position 0: the message is intact.
        w_status = STAT_P0;
      end
      2'b11: begin
        w_status = STAT_SINGLE;
        w_data   = extract_data(w_fixed);
      end
      default: begin
        // Even parity with a nonzero syndrome means two flips; the
        // syndrome is meaningless, so the raw extraction is reported.
        w_status = STAT_DOUBLE;
      end
    endcase
    w_inc1 = (w_status == STAT_SINGLE) || (w_status == STAT_P0);
    w_inc2 = (w_status == STAT_DOUBLE);
  end

  // --------------------------------------------------------------------------
  // FSM, scan datapath and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_code       <= '0;
      r_syn        <= '0;
      r_par        <= 1'b0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_out_data   <= '0;
      r_out_status <= STAT_CLEAN;
      r_err1       <= '0;
      r_err2       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready is registered so it stays low during reset and rises
          // on the first edge after reset releases or after a handoff.
          if (in_valid && r_in_ready) begin
            r_code     <= in_code;
            r_syn      <= '0;
            r_par      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SCAN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        ST_SCAN: begin
          // XOR of the positions of all set bits is the syndrome; bit 0
          // contributes only to parity since its position is zero.
          if (r_code[r_cnt]) begin
            r_syn <= r_syn ^ r_cnt;
            r_par <= ~r_par;
          end
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == c_LAST) begin
            r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          r_out_data   <= w_data;
          r_out_status <= w_status;
          if (w_inc1 && (r_err1 != c_CNT_MAX)) begin
            r_err1 <= r_err1 + 8'd1;
          end
          if (w_inc2 && (r_err2 != c_CNT_MAX)) begin
            r_err2 <= r_err2 + 8'd1;
          end
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) begin
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state == ST_DONE);
  assign out_data   = r_out_data;
  assign out_status = r_out_status;
  assign err1_cnt   = r_err1;
  assign err2_cnt   = r_err2;

endmodule : hamming_secded_decoder
`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_secded_decoder
// Description : Self-checking bench for hamming_secded_decoder. A table of
//               hand-encoded codewords with expected message/status is
//               decoded in a loop; directed sequences cover output hold
//               with back-pressure, reset mid-scan, and counter saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_secded_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [1:0]  out_status;
  logic [7:0]  err1_cnt;
  logic [7:0]  err2_cnt;

  hamming_secded_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .err1_cnt   (err1_cnt),
    .err2_cnt   (err2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [10:0] data;
    logic [1:0]  status;
  } vec_t;

  localparam int c_NVEC = 11;
  vec_t vecs [c_NVEC];

  int n_pass;
  int n_total;
  int exp1;
  int exp2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected counter update derived from the expected status.
  task automatic model_count(input logic [1:0] st);
    if ((st == 2'b01) || (st == 2'b11)) begin
      if (exp1 < 255) exp1++;
    end else if (st == 2'b10) begin
      if (exp2 < 255) exp2++;
    end
  endtask

  // Offer one word, return the number of edges from accept to out_valid.
  // Leaves time at #1 after the edge where out_valid is first seen.
  task automatic send_word(input logic [15:0] code, output int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_code  = code;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_code  = 16'hA5A5;  // must not leak into the word in flight
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [10:0] hold_data;
    logic [1:0]  hold_status;

    n_pass = 0; n_total = 0; exp1 = 0; exp2 = 0;

    //          code       data     status
    vecs[0]  = '{16'h0000, 11'h000, 2'b00};
    vecs[1]  = '{16'hFFDF, 11'h7FF, 2'b01};
    vecs[2]  = '{16'hFFFE, 11'h7FF, 2'b11};
    vecs[3]  = '{16'hFFFC, 11'h7FF, 2'b10};
    vecs[4]  = '{16'h000F, 11'h001, 2'b00};
    vecs[5]  = '{16'h100F, 11'h001, 2'b01};
    vecs[6]  = '{16'h003F, 11'h003, 2'b10};
    vecs[7]  = '{16'h8117, 11'h400, 2'b00};
    vecs[8]  = '{16'h8116, 11'h400, 2'b11};
    vecs[9]  = '{16'h0117, 11'h400, 2'b01};
    vecs[10] = '{16'hFFFF, 11'h7FF, 2'b00};

    reset = 1'b0; in_valid = 1'b0; in_code = 16'h0; out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready",   {31'd0, in_ready},  32'd0);
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",   {21'd0, out_data},  32'd0);
    chk("rst_out_status", {30'd0, out_status},32'd0);
    chk("rst_err1",       {24'd0, err1_cnt},  32'd0);
    chk("rst_err2",       {24'd0, err2_cnt},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_first_edge", {31'd0, in_ready}, 32'd1);

    // Table-driven decode
    for (int v = 0; v < c_NVEC; v++) begin
      send_word(vecs[v].code, lat);
      model_count(vecs[v].status);
      chk($sformatf("latency[%0d]", v), lat, 32'd17);
      chk($sformatf("data[%0d]", v),   {21'd0, out_data},   {21'd0, vecs[v].data});
      chk($sformatf("status[%0d]", v), {30'd0, out_status}, {30'd0, vecs[v].status});
      chk($sformatf("err1[%0d]", v),   {24'd0, err1_cnt},   exp1);
      chk($sformatf("err2[%0d]", v),   {24'd0, err2_cnt},   exp2);
      take_result();
    end

    // Back-pressure: result held 5 cycles, new offer ignored
    send_word(16'h100F, lat);
    model_count(2'b01);
    hold_data   = out_data;
    hold_status = out_status;
    chk("hold_data0", {21'd0, hold_data}, 32'h001);
    in_valid = 1'b1;
    in_code  = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid",    {31'd0, out_valid},  32'd1);
      chk("hold_in_ready", {31'd0, in_ready},   32'd0);
      chk("hold_data",     {21'd0, out_data},   {21'd0, hold_data});
      chk("hold_status",   {30'd0, out_status}, {30'd0, hold_status});
    end
    in_valid = 1'b0;
    take_result();
    chk("hold_err1", {24'd0, err1_cnt}, exp1);
    chk("hold_err2", {24'd0, err2_cnt}, exp2);

    // Reset while scanning at cnt=7
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 16'hFFDF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    exp1 = 0; exp2 = 0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
    chk("abort_err1",      {24'd0, err1_cnt},  32'd0);
    chk("abort_err2",      {24'd0, err2_cnt},  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready_rise", {31'd0, in_ready}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    chk("abort_err1_idle", {24'd0, err1_cnt},  32'd0);
    send_word(16'hFFDF, lat);
    model_count(2'b01);
    chk("post_abort_latency", lat, 32'd17);
    chk("post_abort_data",   {21'd0, out_data},   32'h7FF);
    chk("post_abort_status", {30'd0, out_status}, 32'd1);
    chk("post_abort_err1",   {24'd0, err1_cnt},   exp1);
    take_result();

    // Saturation of the double-error counter
    for (int w = 0; w < 260; w++) begin
      send_word(16'hFFFC, lat);
      model_count(2'b10);
      chk($sformatf("sat_err2[%0d]", w), {24'd0, err2_cnt}, exp2);
      take_result();
    end
    chk("sat_err2_final", {24'd0, err2_cnt}, 32'hFF);
    chk("sat_err1_final", {24'd0, err1_cnt}, exp1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hamming_secded_decoder
`default_nettype wire
